// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for instruction, ALU, condition and status codes.
package y86_pkg;
   localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7;
   localparam logic [3:0] CALL = 4'h8, RET = 4'h9, PUSHQ = 4'hA, POPQ = 4'hB;
   localparam logic [3:0] ALUADD = 4'h0, ALUSUB = 4'h1, ALUAND = 4'h2, ALUXOR = 4'h3;
   localparam logic [3:0] C_YES = 4'h0, C_LE = 4'h1, C_L = 4'h2, C_E = 4'h3;
   localparam logic [3:0] C_NE = 4'h4, C_GE = 4'h5, C_G = 4'h6;
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] AOK = 4'h1, HLT = 4'h2, ADR = 4'h3, INS = 4'h4, BUB = 4'h8;

   function automatic logic cond_eval(input logic [3:0] ifun, input logic zf, input logic sf, input logic of);
      return ifun == C_YES ? 1'b1 :
             ifun == C_LE  ? (sf ^ of) | zf :
             ifun == C_L   ? sf ^ of :
             ifun == C_E   ? zf :
             ifun == C_NE  ? !zf :
             ifun == C_GE  ? !(sf ^ of) :
             ifun == C_G   ? !(sf ^ of) & !zf : 1'b0;
   endfunction

   function automatic logic bad_stat(input logic [3:0] s);
      return s == ADR || s == INS || s == HLT;
   endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational 64-bit Y86 ALU computing B op A plus the flags that result would set.
module alu
   import y86_pkg::*;
(
   input  logic [63:0] alu_a,
   input  logic [63:0] alu_b,
   input  logic [3:0]  alufun,
   output logic [63:0] val_e,
   output logic        zf,
   output logic        sf,
   output logic        of
);
   always_comb begin
      val_e = alufun == ALUADD ? alu_b + alu_a :
              alufun == ALUSUB ? alu_b - alu_a :
              alufun == ALUAND ? alu_b & alu_a :
              alufun == ALUXOR ? alu_b ^ alu_a : 64'd0;
      zf = val_e == 64'd0;
      sf = val_e[63];
      // Overflow only exists for signed add/sub; logical ops always clear it.
      of = alufun == ALUADD ? (alu_a[63] == alu_b[63] && val_e[63] != alu_a[63]) :
           alufun == ALUSUB ? (alu_a[63] != alu_b[63] && val_e[63] != alu_b[63]) : 1'b0;
   end
endmodule

// File: rtl/execute.sv
// execute: Y86-64 pipeline execute stage with condition-code register and M pipeline register.
module execute
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  E_stat,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_ifun,
   input  logic [63:0] E_valA,
   input  logic [63:0] E_valB,
   input  logic [63:0] E_valC,
   input  logic [3:0]  E_dstE,
   input  logic [3:0]  E_dstM,
   input  logic        M_bubble,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  W_stat,
   output logic [63:0] e_valE,
   output logic [3:0]  e_dstE,
   output logic        e_Cnd,
   output logic [3:0]  M_stat,
   output logic [3:0]  M_icode,
   output logic        M_Cnd,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM,
   output logic        ZF,
   output logic        SF,
   output logic        OF
);
   logic [63:0] alu_a, alu_b;
   logic [3:0]  alufun;
   logic        new_zf, new_sf, new_of, set_cc;

   always_comb begin
      alu_a = (E_icode == RRMOVQ || E_icode == OPQ) ? E_valA :
              (E_icode == IRMOVQ || E_icode == RMMOVQ || E_icode == MRMOVQ) ? E_valC :
              (E_icode == CALL || E_icode == PUSHQ) ? 64'hFFFF_FFFF_FFFF_FFF8 :
              (E_icode == RET || E_icode == POPQ) ? 64'd8 : 64'd0;
      alu_b = (E_icode == RMMOVQ || E_icode == MRMOVQ || E_icode == OPQ || E_icode == CALL ||
               E_icode == RET || E_icode == PUSHQ || E_icode == POPQ) ? E_valB : 64'd0;
      alufun = E_icode == OPQ ? E_ifun : ALUADD;
      // Faulting instructions further down the pipe must not have younger ones alter CC.
      set_cc = E_icode == OPQ && E_ifun <= ALUXOR && !bad_stat(m_stat) && !bad_stat(W_stat);
      e_Cnd = (E_icode == RRMOVQ || E_icode == JXX) ? cond_eval(E_ifun, ZF, SF, OF) : 1'b0;
      e_dstE = (E_icode == RRMOVQ && !e_Cnd) ? RNONE : E_dstE;
   end

   alu u_alu (
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alufun(alufun),
      .val_e(e_valE),
      .zf(new_zf),
      .sf(new_sf),
      .of(new_of)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ZF <= 1'b1;
         SF <= 1'b0;
         OF <= 1'b0;
      end else if (set_cc) begin
         ZF <= new_zf;
         SF <= new_sf;
         OF <= new_of;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || M_bubble) begin
         M_stat  <= BUB;
         M_icode <= NOP;
         M_Cnd   <= 1'b0;
         M_valE  <= 64'd0;
         M_valA  <= 64'd0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else begin
         M_stat  <= E_stat;
         M_icode <= E_icode;
         M_Cnd   <= e_Cnd;
         M_valE  <= e_valE;
         M_valA  <= E_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= E_dstM;
      end
   end
endmodule
